// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and helpers for the memory-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Counter width used when the timeout feature is built in.
    localparam int ARB_TIMEOUT_W = 8;

    // Binary index of the set bit; supports up to 64 requesters.
    function automatic logic [7:0] onehot_to_idx(input logic [63:0] onehot);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) begin
                idx = idx | 8'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin pick: rotate by ptr, find first, un-rotate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int nb_bits_select = 2
) (
    input  logic [(2**nb_bits_select)-1:0] i_req,
    input  logic [nb_bits_select-1:0]      i_ptr,
    output logic                           o_valid,
    output logic [nb_bits_select-1:0]      o_index
);

    localparam int c_N  = 2**nb_bits_select;
    localparam int c_SW = nb_bits_select;

    logic [c_N-1:0]  w_rot;
    logic [c_SW-1:0] w_off;
    logic [c_SW-1:0] w_src;
    logic            w_found;

    always_comb begin
        w_rot   = '0;
        w_off   = '0;
        w_src   = '0;
        w_found = 1'b0;
        // N is a power of two, so the SW-bit sum wraps modulo N for free.
        for (int i = 0; i < c_N; i++) begin
            w_src    = c_SW'(i) + i_ptr;
            w_rot[i] = i_req[w_src];
        end
        for (int i = 0; i < c_N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_SW'(i);
            end
        end
    end

    assign o_valid = w_found;
    assign o_index = w_off + i_ptr;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin, transaction-holding arbiter for one shared port.
//            Optional macro ARB_TIMEOUT_EN adds a forced-release timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int nb_bits_select = 2,
    parameter int timeout_cycles = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [(2**nb_bits_select)-1:0] req_i,
    input  logic                           rsp_valid_i,
    output logic [(2**nb_bits_select)-1:0] grant_o,
    output logic [nb_bits_select-1:0]      sel_o,
    output logic                           busy_o,
    output logic [(2**nb_bits_select)-1:0] rsp_valid_o,
    output logic                           timeout_o
);

    localparam int c_N  = 2**nb_bits_select;
    localparam int c_SW = nb_bits_select;

    arb_state_t      state_q, state_d;
    logic [c_N-1:0]  grant_q, grant_d;
    logic [c_SW-1:0] sel_q, sel_d;
    logic [c_SW-1:0] ptr_q, ptr_d;

    logic [c_N-1:0]  w_pick_req;
    logic [c_SW-1:0] w_pick_ptr;
    logic            w_pick_valid;
    logic [c_SW-1:0] w_pick_idx;
    logic [c_SW-1:0] w_cur;
    logic [c_SW-1:0] w_next;
    logic [c_N-1:0]  w_pick_oh;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TO_W = ARB_TIMEOUT_W;
    logic [c_TO_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    assign w_cur     = c_SW'(onehot_to_idx(64'(grant_q)));
    assign w_next    = w_cur + c_SW'(1);
    assign w_pick_oh = {{(c_N-1){1'b0}}, 1'b1} << w_pick_idx;

    // While busy the picker serves back-to-back hand-over: start after the
    // current owner and never pick it again on the same edge.
    always_comb begin
        w_pick_req = req_i;
        w_pick_ptr = ptr_q;
        if (state_q == ARB_BUSY) begin
            w_pick_req = req_i & ~grant_q;
            w_pick_ptr = w_next;
        end
    end

    rr_priority_picker #(
        .nb_bits_select (nb_bits_select)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_ptr   (w_pick_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = w_pick_oh;
                    sel_d   = w_pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (rsp_valid_i) begin
                    ptr_d = w_next;
                    if (w_pick_valid) begin
                        grant_d = w_pick_oh;
                        sel_d   = w_pick_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end else if ((req_i & grant_q) == '0) begin
                    ptr_d   = w_next;
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == c_TO_W'(timeout_cycles - 1)) begin
                    ptr_d     = w_next;
                    state_d   = ARB_IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_TO_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // timeout_cycles has no effect without the timeout feature.
    if (timeout_cycles < 1) begin : g_no_timeout
    end

    assign timeout_o = 1'b0;
`endif

    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q == ARB_BUSY);
    assign rsp_valid_o = grant_q & {c_N{rsp_valid_i}};

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scenarios plus randomized run against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int NB = 2;
    localparam int N  = 4;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] req_i = '0;
    logic         rsp_valid_i = 1'b0;
    logic [N-1:0] grant_o;
    logic [NB-1:0] sel_o;
    logic         busy_o;
    logic [N-1:0] rsp_valid_o;
    logic         timeout_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .nb_bits_select (NB),
        .timeout_cycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .rsp_valid_i (rsp_valid_i),
        .grant_o     (grant_o),
        .sel_o       (sel_o),
        .busy_o      (busy_o),
        .rsp_valid_o (rsp_valid_o),
        .timeout_o   (timeout_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = '0; rsp_valid_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        total++; if (sel_o !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
        total++; if (rsp_valid_o !== 4'b0000) begin bad++; $display("FAIL reset_rspo got=%b exp=0000", rsp_valid_o); end
    endtask

    task automatic test_first_grant();
        do_reset();
        req_i = 4'b0100;
        step();
        total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL first_grant got=%b exp=0100", grant_o); end
        total++; if (sel_o !== 2'd2) begin bad++; $display("FAIL first_sel got=%0d exp=2", sel_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp;
        do_reset();
        req_i = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % N);
            for (int c = 0; c < 3; c++) begin
                rsp_valid_i = (c == 2);
                #1;
                total++; if (grant_o !== exp || busy_o !== 1'b1) begin bad++; $display("FAIL rr_grant k=%0d c=%0d got=%b/%b exp=%b/1", k, c, grant_o, busy_o, exp); end
                if (c == 2) begin
                    total++; if (rsp_valid_o !== exp) begin bad++; $display("FAIL rr_rspo k=%0d got=%b exp=%b", k, rsp_valid_o, exp); end
                end
                step();
            end
        end
        rsp_valid_i = 1'b0;
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL rr_after_wrap got=%b exp=0010", grant_o); end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req_i = 4'b0010;
        step();
        req_i = 4'b1010;
        step(); step();
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL nopre_hold got=%b exp=0010", grant_o); end
        rsp_valid_i = 1'b1;
        #1;
        total++; if (rsp_valid_o !== 4'b0010) begin bad++; $display("FAIL nopre_rspo got=%b exp=0010", rsp_valid_o); end
        step();
        rsp_valid_i = 1'b0;
        req_i = 4'b1000;
        total++; if (grant_o !== 4'b1000 || sel_o !== 2'd3) begin bad++; $display("FAIL nopre_next got=%b/%0d exp=1000/3", grant_o, sel_o); end
    endtask

    task automatic test_abort();
        do_reset();
        req_i = 4'b0100;
        step();
        req_i = 4'b0000;
        #1;
        total++; if (rsp_valid_o !== 4'b0000) begin bad++; $display("FAIL abort_rspo got=%b exp=0000", rsp_valid_o); end
        step();
        total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("FAIL abort_release got=%b/%b exp=0000/0", grant_o, busy_o); end
        req_i = 4'b1111;
        step();
        total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL abort_ptr got=%b exp=1000", grant_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i = 4'b0100;
        step();
        req_i = 4'b0000; rsp_valid_i = 1'b1;
        step();
        rsp_valid_i = 1'b0; req_i = 4'b0001;
        step();
        total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rstmid_pre got=%b exp=0001", grant_o); end
        rst_i = 1'b1;
        step();
        total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || sel_o !== 2'd0 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%b/%0d/%b exp=0000/0/0/0", grant_o, busy_o, sel_o, timeout_o);
        end
        rst_i = 1'b0; req_i = 4'b1111;
        step();
        total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rstmid_ptr got=%b exp=0001", grant_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        req_i = 4'b0001;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step();
            total++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin bad++; $display("FAIL to_early i=%0d got=%b/%b exp=1/0", i, busy_o, timeout_o); end
        end
        step();
        total++; if (grant_o !== 4'b0000 || timeout_o !== 1'b1) begin bad++; $display("FAIL to_fire got=%b/%b exp=0000/1", grant_o, timeout_o); end
        step();
        total++; if (grant_o !== 4'b0001 || timeout_o !== 1'b0) begin bad++; $display("FAIL to_regrant got=%b/%b exp=0001/0", grant_o, timeout_o); end
        for (int i = 1; i < TO; i++) step();
        rsp_valid_i = 1'b1;
        step();
        rsp_valid_i = 1'b0;
        total++; if (timeout_o !== 1'b0 || grant_o !== 4'b0000) begin bad++; $display("FAIL to_rsp_wins got=%b/%b exp=0000/0", grant_o, timeout_o); end
`else
        for (int i = 0; i < 40; i++) step();
        total++; if (grant_o !== 4'b0001 || busy_o !== 1'b1) begin bad++; $display("FAIL hold_forever got=%b/%b exp=0001/1", grant_o, busy_o); end
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL no_timeout got=%b exp=0", timeout_o); end
`endif
    endtask

    task automatic test_random();
        int m_gnt, m_ptr, m_sel, m_bc, last_done, nxt, cand;
        bit m_tmo, found;
        logic [N-1:0] exp_g, exp_r;
        do_reset();
        m_gnt = -1; m_ptr = 0; m_sel = 0; m_bc = 0; m_tmo = 0; last_done = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_i[i]) begin
                    if ($urandom_range(3) == 0) req_i[i] = 1'b1;
                end else if (i == last_done && $urandom_range(1) == 0) begin
                    req_i[i] = 1'b0;
                end else if (i == m_gnt && $urandom_range(19) == 0) begin
                    req_i[i] = 1'b0;
                end
            end
            rsp_valid_i = ($urandom_range(2) == 0);
            #1;
            exp_r = (m_gnt >= 0 && rsp_valid_i) ? (4'b0001 << m_gnt) : 4'b0000;
            total++; if (rsp_valid_o !== exp_r) begin bad++; $display("FAIL rnd_rspo cyc=%0d got=%b exp=%b", cyc, rsp_valid_o, exp_r); end

            m_tmo = 0; last_done = -1; found = 0; nxt = 0;
            if (m_gnt < 0) begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (!found && req_i[cand]) begin found = 1; nxt = cand; end
                end
                if (found) begin m_gnt = nxt; m_sel = nxt; m_bc = 0; end
            end else if (rsp_valid_i) begin
                last_done = m_gnt;
                m_ptr = (m_gnt + 1) % N;
                for (int k = 0; k < N - 1; k++) begin
                    cand = (m_gnt + 1 + k) % N;
                    if (!found && req_i[cand]) begin found = 1; nxt = cand; end
                end
                if (found) begin m_gnt = nxt; m_sel = nxt; m_bc = 0; end
                else m_gnt = -1;
            end else if (!req_i[m_gnt]) begin
                m_ptr = (m_gnt + 1) % N;
                m_gnt = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                m_bc++;
                if (m_bc == TO) begin
                    m_ptr = (m_gnt + 1) % N;
                    m_gnt = -1;
                    m_tmo = 1;
                end
            end
`endif
            step();
            exp_g = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
            total++; if (grant_o !== exp_g) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant_o, exp_g); end
            total++; if (sel_o !== NB'(m_sel)) begin bad++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", cyc, sel_o, m_sel); end
            total++; if (busy_o !== (m_gnt >= 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, (m_gnt >= 0)); end
            total++; if (timeout_o !== m_tmo) begin bad++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, timeout_o, m_tmo); end
        end
        rsp_valid_i = 1'b0;
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_no_preempt();
        test_abort();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one single-ported resource (data memory / register-file write port) between 2**nb_bits_select requesters.
- Drives the select input of the generic N:1 data multiplexer placed in front of the resource, and routes the resource's completion pulse back to the granted requester.
- Grant is held for a whole transaction, from grant until completion.
- Sits between the core's load/store and auxiliary masters and the shared port.

Parameters:
- nb_bits_select, 2, select width; number of requesters N = 2**nb_bits_select (N >= 2).
- timeout_cycles, 15, busy-cycle limit before forced release (used only with ARB_TIMEOUT_EN).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  N  request per requester; level, held until served.
- rsp_valid_i  input  1  one-cycle pulse from resource: current transaction done.
- grant_o  output  N  one-hot grant, registered.
- sel_o  output  nb_bits_select  binary index of granted requester; drives mux select.
- busy_o  output  1  high while a grant is active.
- rsp_valid_o  output  N  rsp_valid_i routed to granted requester (combinational AND with grant_o).
- timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset: state ARB_IDLE, grant_o=0, sel_o=0, busy_o=0, timeout_o=0, priority pointer ptr=0, timeout counter=0. Reset mid-transaction drops the grant at that edge, with no rsp_valid_o.
- States: ARB_IDLE, ARB_BUSY.
- Arbitration: the first asserted req_i scanning ptr, ptr+1, ..., ptr+N-1 (mod N) wins.
- ARB_IDLE, any req_i high at edge k:
  - grant_o and sel_o registered to the winner.
  - busy_o=1 from cycle k+1.
  - Latency is 1 cycle, request to grant.
- ARB_IDLE, no request: outputs unchanged at 0; sel_o keeps its last value.
- ARB_BUSY:
  - grant_o and sel_o are frozen; new requests do not preempt.
  - rsp_valid_o[g] = rsp_valid_i while grant g is active; 0 otherwise. rsp_valid_i in ARB_IDLE is ignored.
- Completion (rsp_valid_i=1 in ARB_BUSY, grant g):
  - ptr <= g+1 mod N (wrap from N-1 to 0).
  - Back-to-back: the same edge re-arbitrates from g+1 excluding g. If another requester is pending, grant moves to it directly (no idle cycle) and state stays ARB_BUSY. Otherwise grant_o is cleared and state goes to ARB_IDLE.
  - If only g is still requesting, it gets no grant that edge. It is re-granted on the next ARB_IDLE edge, giving 1 idle cycle.
- Abort: granted req_i low in ARB_BUSY without rsp_valid_i releases the grant next edge. ptr <= g+1; no rsp_valid_o; state goes to ARB_IDLE.
- Simultaneous abort and rsp_valid_i: treated as completion (rsp_valid_o asserted).
- grant_o is always one-hot or zero. sel_o equals the index of grant_o whenever busy_o=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on each new grant and increments each cycle in ARB_BUSY.
  - When it reaches timeout_cycles without rsp_valid_i, the grant is released as an abort, ptr <= g+1, and timeout_o pulses for 1 cycle.
  - rsp_valid_i on the same cycle wins; no timeout.
- Undefined: no counter; timeout_o tied 0; grant held indefinitely.

Decomposition:
- Package arb_pkg: typedef enum logic arb_state_t {ARB_IDLE, ARB_BUSY}; function onehot_to_idx; localparam default timeout width.
- Sub-module rr_priority_picker: combinational rotate-by-ptr, find-first-set, and un-rotate. Inputs req and ptr; outputs valid and index. Instantiated once.

Test Plan:
- Reset, then req_i=4'b0100 at cycle 0 -> grant_o=4'b0100, sel_o=2, busy_o=1 at cycle 1.
- All four requesting constantly, rsp_valid_i every 3rd cycle from ptr=0 -> grants 0,1,2,3,0 in order with no idle cycles; ptr wraps 3->0.
- Grant to 1, req_i[3] rises mid-transaction -> grant stays 4'b0010 until rsp_valid_i; rsp_valid_o=4'b0010 on that cycle; next grant 4'b1000.
- Granted requester 2 drops req_i before rsp -> grant cleared next edge, rsp_valid_o stays 0, ptr=3.
- rst_i high during ARB_BUSY with grant 4'b0001 -> next edge all outputs 0, ptr=0.
- ARB_TIMEOUT_EN, timeout_cycles=15, no rsp -> release after 15 busy cycles, timeout_o pulse; rsp_valid_i on cycle 15 -> no timeout.
